// File: rtl/dm_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter.
//   MEM_W / MEM_H / MEM_B : CPU access-size encodings on cpu_size
//   dm_state_e            : arbiter FSM states (IDLE, CPU owns memory, DMA owns memory)
//   FAIR_W                : width of the fairness counter (FAIR_LIMIT must fit)
//   word_addr()           : byte address -> word-aligned memory address
package dm_access_arbiter_pkg;

    localparam logic [1:0] MEM_W = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_B = 2'b10;

    localparam int FAIR_W = 8;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'b00,
        DMA_CPU  = 2'b01,
        DMA_DMA  = 2'b10
    } dm_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dm_access_arbiter_lane_gen.sv
// dm_lane_gen: purely combinational lane steering for CPU accesses.
//   size       in  2   MEM_W / MEM_H / MEM_B
//   addr_lo    in  2   byte offset within the word
//   wdata      in  32  store data, low bytes significant for h/b
//   we         in  1   1 = store
//   be         out 4   byte enables (0000 for loads)
//   lane_wdata out 32  store data replicated across all lanes of its width
//   misaligned out 1   word not on a 4-byte boundary or half on an odd byte
module dm_lane_gen
    import dm_access_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misaligned
);

    logic [3:0] be_raw;

    always_comb begin
        be_raw     = 4'b1111;
        lane_wdata = wdata;
        misaligned = 1'b0;
        case (size)
            MEM_B: begin
                be_raw     = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            MEM_H: begin
                be_raw     = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            // MEM_W and the unused encoding are both treated as a word access.
            default: begin
                be_raw     = 4'b1111;
                lane_wdata = wdata;
                misaligned = |addr_lo;
            end
        endcase
        be = we ? be_raw : 4'b0000;
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: owns the single-port data memory and shares it between the
// M-stage load/store port and a word-only DMA/debug port.
//   clk, reset                 clock and synchronous active-high reset
//   cpu_req/we/size/addr/wdata M-stage access, held until cpu_stall drops
//   cpu_stall, cpu_rdata       pipeline freeze and raw read word
//   cpu_addr_err               misaligned CPU access (no memory access made)
//   dma_req/we/addr/wdata      DMA word access, held until dma_done
//   dma_done, dma_rdata        1-cycle completion pulse and latched read word
//   mem_en/be/addr/wdata       memory request, held until mem_ready
//   mem_rdata, mem_ready       memory response
//   dbg_state, dbg_fair_cnt    FSM state and fairness counter for observation
//
// Handshakes: a requester raises its req with stable payload and keeps it
// until completion (cpu: cycle with cpu_stall=0; dma: dma_done pulse). Toward
// memory, mem_en is the valid and mem_ready the ready; the transfer happens in
// the cycle both are high, and mem_ready may arrive in the first mem_en cycle.
// After every completion the FSM spends at least one cycle in IDLE.
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_addr_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_done,
    output logic [31:0]       dma_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state,
    output logic [FAIR_W-1:0] dbg_fair_cnt
);

    localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

    dm_state_e         state, state_n;
    logic [FAIR_W-1:0] fair_cnt;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_misaligned;
    logic        cpu_ok;
    logic        grant_cpu;
    logic        grant_dma;

    dm_lane_gen u_lane_gen (
        .size       (cpu_size),
        .addr_lo    (cpu_addr[1:0]),
        .wdata      (cpu_wdata),
        .we         (cpu_we),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .misaligned (lane_misaligned)
    );

    // Error and stall are pure functions of the current request and state so
    // the pipeline sees them in the same cycle the access is presented.
    assign cpu_addr_err = cpu_req & lane_misaligned;
    assign cpu_ok       = cpu_req & ~lane_misaligned;
    assign cpu_stall    = cpu_ok & ~((state == DMA_CPU) & mem_ready);
    assign cpu_rdata    = mem_rdata;

    assign dbg_state    = state;
    assign dbg_fair_cnt = fair_cnt;

    // Next-state and grant decision. The CPU wins a tie unless it has
    // already taken FAIR_LIMIT grants while the DMA was waiting.
    always_comb begin
        state_n   = state;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        case (state)
            DMA_IDLE: begin
                if (dma_req && (!cpu_ok || fair_cnt == FAIR_MAX)) begin
                    grant_dma = 1'b1;
                    state_n   = DMA_DMA;
                end else if (cpu_ok) begin
                    grant_cpu = 1'b1;
                    state_n   = DMA_CPU;
                end
            end
            DMA_CPU, DMA_DMA: begin
                if (mem_ready) begin
                    state_n = DMA_IDLE;
                end
            end
            default: state_n = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DMA_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Memory request registers and DMA result. A reset while busy abandons the
    // access: mem_en drops at that edge and any late mem_ready is ignored
    // because the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            dma_done  <= 1'b0;
            dma_rdata <= 32'h0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                DMA_IDLE: begin
                    if (grant_dma) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= word_addr(dma_addr);
                        mem_be    <= dma_we ? 4'b1111 : 4'b0000;
                        mem_wdata <= dma_wdata;
                    end else if (grant_cpu) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= word_addr(cpu_addr);
                        mem_be    <= lane_be;
                        mem_wdata <= lane_wdata;
                    end
                end
                DMA_CPU: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                    end
                end
                DMA_DMA: begin
                    if (mem_ready) begin
                        mem_en    <= 1'b0;
                        dma_done  <= 1'b1;
                        dma_rdata <= mem_rdata;
                    end
                end
                default: mem_en <= 1'b0;
            endcase
        end
    end

    // Fairness counter: counts CPU grants that overtook a waiting DMA request.
    always_ff @(posedge clk) begin
        if (reset) begin
            fair_cnt <= '0;
        end else if (!dma_req || grant_dma) begin
            fair_cnt <= '0;
        end else if (grant_cpu && fair_cnt != FAIR_MAX) begin
            fair_cnt <= fair_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed + randomized bench for dm_access_arbiter. A memory responder raises
// mem_ready after a programmable number of mem_en cycles; every completed
// memory access is compared against an expected queue filled when stimulus
// is driven.
module tb_dm_access_arbiter;
    import dm_access_arbiter_pkg::*;

    localparam int W = 68;  // {be[3:0], addr[31:0], wdata[31:0]}

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_addr_err;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_done;
    logic [31:0] dma_rdata;
    logic        mem_en;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_fair_cnt;

    int          mem_lat;
    int          en_cnt;
    logic [31:0] rd_word;

    logic [W-1:0] exp_q[$];
    int n_asserts;
    int n_fail;

    dm_access_arbiter #(.FAIR_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_rdata    (cpu_rdata),
        .cpu_addr_err (cpu_addr_err),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_done     (dma_done),
        .dma_rdata    (dma_rdata),
        .mem_en       (mem_en),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .dbg_state    (dbg_state),
        .dbg_fair_cnt (dbg_fair_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    assign mem_ready = mem_en && (en_cnt == mem_lat - 1);
    assign mem_rdata = rd_word;

    always @(posedge clk) begin
        if (reset || !mem_en || mem_ready) en_cnt <= 0;
        else                               en_cnt <= en_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed memory transfer must match the head of exp_q.
    // Write data is only meaningful when the expected access has byte enables.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] o;
        if (!reset && mem_en && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_mem_access", {mem_be, mem_addr, mem_wdata}, '0);
            end else begin
                e = exp_q.pop_front();
                o = {mem_be, mem_addr, (e[67:64] == 4'b0000) ? 32'h0 : mem_wdata};
                check("mem_access", o, e);
            end
        end
    end

    // Independent model of the expected memory request for a CPU access.
    function automatic logic [W-1:0] exp_access(input logic [1:0] size, input logic we,
                                                input logic [31:0] addr, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] d;
        be = 4'hF;
        d  = wd;
        if (size == MEM_B) begin
            d = {4{wd[7:0]}};
            case (addr[1:0])
                2'd0:    be = 4'b0001;
                2'd1:    be = 4'b0010;
                2'd2:    be = 4'b0100;
                default: be = 4'b1000;
            endcase
        end else if (size == MEM_H) begin
            d  = {2{wd[15:0]}};
            be = addr[1] ? 4'b1100 : 4'b0011;
        end
        if (!we) begin
            be = 4'b0000;
            d  = 32'h0;
        end
        return {be, {addr[31:2], 2'b00}, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one CPU access and hold it until released; reports stall cycles.
    task automatic run_cpu(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
        logic done;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_size  = size;
        cpu_addr  = addr;
        cpu_wdata = wd;
        stalls    = 0;
        rdata     = 32'h0;
        done      = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                rdata = cpu_rdata;
                done  = 1'b1;
            end else begin
                stalls++;
            end
            next_cycle();
        end
        check("cpu_release_timeout", W'(done), W'(1));
        cpu_req = 1'b0;
    endtask

    // One DMA word access; checks the dma_done pulse position and read data.
    task automatic run_dma(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int lat, input logic [31:0] rword);
        logic prev_ready;
        logic got;
        dma_req    = 1'b1;
        dma_we     = we;
        dma_addr   = addr;
        dma_wdata  = wd;
        mem_lat    = lat;
        rd_word    = rword;
        prev_ready = 1'b0;
        got        = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (prev_ready) begin
                check("dma_done_pulse", W'(dma_done), W'(1));
                check("dma_rdata", W'(dma_rdata), W'(rword));
                got     = 1'b1;
                dma_req = 1'b0;
                rd_word = 32'h0;
            end else begin
                check("dma_done_early", W'(dma_done), W'(0));
            end
            prev_ready = mem_en && mem_ready;
            next_cycle();
        end
        check("dma_done_timeout", W'(got), W'(1));
        @(negedge clk);
        check("dma_done_width", W'(dma_done), W'(0));
        check("dma_rdata_held", W'(dma_rdata), W'(rword));
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          stalls;
        logic [31:0] rdata;
        int          cpu_seen;
        int          dma_seen;
        int          cpu_at_dma;
        logic [1:0]  sz;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;

        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_size  = MEM_W;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = 32'h0;
        dma_wdata = 32'h0;
        mem_lat   = 1;
        rd_word   = 32'h0;

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_state",    W'(dbg_state), W'(DMA_IDLE));
        check("rst_mem_en",   W'(mem_en), W'(0));
        check("rst_mem_be",   W'(mem_be), W'(0));
        check("rst_mem_addr", W'(mem_addr), W'(0));
        check("rst_mem_wdata", W'(mem_wdata), W'(0));
        check("rst_dma_done", W'(dma_done), W'(0));
        check("rst_fair_cnt", W'(dbg_fair_cnt), W'(0));
        check("rst_cpu_stall", W'(cpu_stall), W'(0));
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // sb 0x1003, ready in first mem_en cycle
        mem_lat = 1;
        exp_q.push_back({4'b1000, 32'h0000_1000, 32'hABAB_ABAB});
        run_cpu(1'b1, MEM_B, 32'h0000_1003, 32'h0000_00AB, stalls, rdata);
        check("sb_stall_cycles", W'(stalls), W'(1));
        next_cycle();

        // lw 0x2000, ready after 3 mem_en cycles
        mem_lat = 3;
        rd_word = 32'hDEAD_BEEF;
        exp_q.push_back({4'b0000, 32'h0000_2000, 32'h0});
        run_cpu(1'b0, MEM_W, 32'h0000_2000, 32'h1234_5678, stalls, rdata);
        check("lw_stall_cycles", W'(stalls), W'(3));
        check("lw_cpu_rdata", W'(rdata), W'(32'hDEAD_BEEF));
        next_cycle();

        // Misaligned sh 0x0001 and lw 0x2002: flagged, never granted
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_size  = MEM_H;
        cpu_addr  = 32'h0000_0001;
        cpu_wdata = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sh_mis_err",   W'(cpu_addr_err), W'(1));
            check("sh_mis_stall", W'(cpu_stall), W'(0));
            check("sh_mis_mem_en", W'(mem_en), W'(0));
            next_cycle();
        end
        cpu_we   = 1'b0;
        cpu_size = MEM_W;
        cpu_addr = 32'h0000_2002;
        @(negedge clk);
        check("lw_mis_err",   W'(cpu_addr_err), W'(1));
        check("lw_mis_stall", W'(cpu_stall), W'(0));
        next_cycle();
        @(negedge clk);
        check("lw_mis_mem_en", W'(mem_en), W'(0));
        cpu_req = 1'b0;
        @(negedge clk);
        check("no_req_err", W'(cpu_addr_err), W'(0));
        next_cycle();

        // Fairness: continuous CPU loads against a held DMA write
        mem_lat   = 1;
        rd_word   = 32'h0BAD_F00D;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_size  = MEM_W;
        cpu_addr  = 32'h0000_0100;
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 32'h0000_4000;
        dma_wdata = 32'h55AA_55AA;
        for (int i = 0; i < 4; i++) exp_q.push_back({4'b0000, 32'h0000_0100, 32'h0});
        exp_q.push_back({4'b1111, 32'h0000_4000, 32'h55AA_55AA});
        exp_q.push_back({4'b0000, 32'h0000_0100, 32'h0});
        cpu_seen   = 0;
        dma_seen   = 0;
        cpu_at_dma = -1;
        for (int i = 0; i < 60 && cpu_seen < 5; i++) begin
            @(negedge clk);
            if (!cpu_stall) cpu_seen++;
            if (dma_done) begin
                dma_seen++;
                cpu_at_dma = cpu_seen;
                check("fair_cnt_after_dma", W'(dbg_fair_cnt), W'(0));
                dma_req = 1'b0;
            end
            next_cycle();
        end
        cpu_req = 1'b0;
        check("fair_cpu_count", W'(cpu_seen), W'(5));
        check("fair_dma_pulses", W'(dma_seen), W'(1));
        check("fair_cpu_before_dma", W'(cpu_at_dma), W'(4));
        @(negedge clk);
        check("fair_cnt_idle", W'(dbg_fair_cnt), W'(0));
        next_cycle();

        // DMA read 0x3004 alone, then a read whose low address bits are ignored,
        // then a DMA write
        exp_q.push_back({4'b0000, 32'h0000_3004, 32'h0});
        run_dma(1'b0, 32'h0000_3004, 32'h0, 2, 32'hCAFE_F00D);
        exp_q.push_back({4'b0000, 32'h0000_3004, 32'h0});
        run_dma(1'b0, 32'h0000_3007, 32'h0, 1, 32'h1357_9BDF);
        exp_q.push_back({4'b1111, 32'h0000_3008, 32'hA5A5_0F0F});
        run_dma(1'b1, 32'h0000_300B, 32'hA5A5_0F0F, 3, 32'h2468_ACE0);

        // Randomized aligned CPU accesses
        for (int n = 0; n < 10; n++) begin
            sz   = 2'($urandom_range(0, 2));
            we   = 1'($urandom_range(0, 1));
            addr = 32'h0000_8000 | (32'($urandom_range(0, 255)) << 2);
            if (sz == MEM_B)      addr[1:0] = 2'($urandom_range(0, 3));
            else if (sz == MEM_H) addr[1]   = 1'($urandom_range(0, 1));
            wd      = $urandom;
            lat     = $urandom_range(1, 4);
            mem_lat = lat;
            rd_word = $urandom;
            exp_q.push_back(exp_access(sz, we, addr, wd));
            run_cpu(we, sz, addr, wd, stalls, rdata);
            check("rand_stall_cycles", W'(stalls), W'(lat));
            if (!we) check("rand_cpu_rdata", W'(rdata), W'(rd_word));
            next_cycle();
        end

        // Reset while the CPU owns the memory (memory never answers)
        mem_lat   = 1000;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_size  = MEM_W;
        cpu_addr  = 32'h0000_0500;
        cpu_wdata = 32'h0F0F_F0F0;
        next_cycle();
        @(negedge clk);
        check("busy_state",  W'(dbg_state), W'(DMA_CPU));
        check("busy_mem_en", W'(mem_en), W'(1));
        check("busy_stall",  W'(cpu_stall), W'(1));
        next_cycle();
        reset   = 1'b1;
        cpu_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("midrst_state",     W'(dbg_state), W'(DMA_IDLE));
        check("midrst_mem_en",    W'(mem_en), W'(0));
        check("midrst_mem_be",    W'(mem_be), W'(0));
        check("midrst_mem_addr",  W'(mem_addr), W'(0));
        check("midrst_mem_wdata", W'(mem_wdata), W'(0));
        check("midrst_dma_done",  W'(dma_done), W'(0));
        check("midrst_dma_rdata", W'(dma_rdata), W'(0));
        check("midrst_fair_cnt",  W'(dbg_fair_cnt), W'(0));
        next_cycle();
        reset = 1'b0;
        next_cycle();
        next_cycle();

        check("scoreboard_drained", W'(exp_q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
